llc_input_stage: RTL and testbench

LLC_INPUT_STAGE -- requirements
Module: llc_input_stage

---
 rtl/llc_input_stage_pkg.sv | 37 +++
 rtl/llc_input_fifo.sv | 104 ++++++++++
 rtl/llc_input_stage.sv | 126 ++++++++++++
 tb/tb_llc_input_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_input_stage_pkg.sv
// +----------------------------------------------------------------------+
// | llc_input_stage_pkg : shared cache types for the LLC input stage     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package llc_input_stage_pkg;

  localparam int unsigned c_LINE_ADDR_BITS = 26;
  localparam int unsigned c_MSG_BITS       = 4;
  localparam int unsigned c_NUM_CH         = 4;

  // Only these two queue depths are supported.
  localparam int unsigned c_DEPTH_MIN      = 2;
  localparam int unsigned c_DEPTH_MAX      = 4;

  typedef logic [c_LINE_ADDR_BITS-1:0] line_addr_t;

  typedef struct packed {
    line_addr_t              addr;
    logic [c_MSG_BITS-1:0]   msg;
  } llc_in_pkt_t;

  typedef enum logic [1:0] {
    CH_RST_TB     = 2'd0,
    CH_RSP_IN     = 2'd1,
    CH_REQ_IN     = 2'd2,
    CH_DMA_REQ_IN = 2'd3
  } llc_in_ch_e;

  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth == c_DEPTH_MIN) || (depth == c_DEPTH_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/llc_input_fifo.sv
// +----------------------------------------------------------------------+
// | llc_input_fifo : one channel queue with sticky underflow flag;       |
// | optional accept counter under LLC_INPUT_STATS_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module llc_input_fifo
  import llc_input_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid_i,
  output logic        push_ready_o,
  input  llc_in_pkt_t push_data_i,
  input  logic        pop_i,
  output logic        head_valid_o,
  output llc_in_pkt_t head_o,
  output logic        underflow_o
`ifdef LLC_INPUT_STATS_EN
  ,
  output logic [15:0] accept_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (!depth_is_legal(DEPTH)) begin : g_depth_check
    $error("llc_input_fifo: DEPTH must be 2 or 4");
  end

  llc_in_pkt_t   r_mem_q [DEPTH];
  logic [PW-1:0] r_wptr_q, r_wptr_d;
  logic [PW-1:0] r_rptr_q, r_rptr_d;
  logic [CW-1:0] r_count_q, r_count_d;
  logic          r_underflow_q, r_underflow_d;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  assign w_empty      = (r_count_q == '0);
  // Ready depends on registered occupancy only, so a same-cycle pop never frees a full slot.
  assign push_ready_o = rst && (r_count_q != CW'(DEPTH));
  assign w_push       = push_valid_i && push_ready_o;
  assign w_pop        = pop_i && !w_empty;
  assign head_valid_o = !w_empty;
  assign head_o       = r_mem_q[r_rptr_q];
  assign underflow_o  = r_underflow_q;

  always_comb begin
    r_wptr_d      = r_wptr_q;
    r_rptr_d      = r_rptr_q;
    r_count_d     = r_count_q;
    r_underflow_d = r_underflow_q | (pop_i && w_empty);
    if (w_push) r_wptr_d = r_wptr_q + 1'b1;
    if (w_pop)  r_rptr_d = r_rptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   r_count_d = r_count_q + 1'b1;
      2'b01:   r_count_d = r_count_q - 1'b1;
      default: r_count_d = r_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr_q      <= '0;
      r_rptr_q      <= '0;
      r_count_q     <= '0;
      r_underflow_q <= 1'b0;
    end else begin
      r_wptr_q      <= r_wptr_d;
      r_rptr_q      <= r_rptr_d;
      r_count_q     <= r_count_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem_q[i] <= '0;
    end else if (w_push) begin
      r_mem_q[r_wptr_q] <= push_data_i;
    end
  end

`ifdef LLC_INPUT_STATS_EN
  logic [15:0] r_accept_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_accept_cnt_q <= '0;
    end else if (w_push && (r_accept_cnt_q != 16'hFFFF)) begin
      r_accept_cnt_q <= r_accept_cnt_q + 16'd1;
    end
  end

  assign accept_cnt_o = r_accept_cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/llc_input_stage.sv
// +----------------------------------------------------------------------+
// | llc_input_stage : four independent per-channel input queues feeding  |
// | the LLC decoder; LLC_INPUT_STATS_EN adds accept counters. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module llc_input_stage
  import llc_input_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        rst_tb_valid,
  output logic        rst_tb_ready,
  input  llc_in_pkt_t rst_tb_data,
  output logic        llc_rst_tb_valid_int,
  output llc_in_pkt_t rst_tb_head,
  input  logic        get_rst_tb,

  input  logic        rsp_in_valid,
  output logic        rsp_in_ready,
  input  llc_in_pkt_t rsp_in_data,
  output logic        llc_rsp_in_valid_int,
  output llc_in_pkt_t rsp_in_head,
  input  logic        get_rsp_in,

  input  logic        req_in_valid,
  output logic        req_in_ready,
  input  llc_in_pkt_t req_in_data,
  output logic        llc_req_in_valid_int,
  output llc_in_pkt_t req_in_head,
  input  logic        get_req_in,

  input  logic        dma_req_in_valid,
  output logic        dma_req_in_ready,
  input  llc_in_pkt_t dma_req_in_data,
  output logic        llc_dma_req_in_valid_int,
  output llc_in_pkt_t dma_req_in_head,
  input  logic        get_dma_req_in,

  output logic        underflow_err
`ifdef LLC_INPUT_STATS_EN
  ,
  output logic [15:0] rst_tb_accept_cnt,
  output logic [15:0] rsp_in_accept_cnt,
  output logic [15:0] req_in_accept_cnt,
  output logic [15:0] dma_req_in_accept_cnt
`endif
);

  logic [c_NUM_CH-1:0] w_valid;
  logic [c_NUM_CH-1:0] w_ready;
  logic [c_NUM_CH-1:0] w_get;
  logic [c_NUM_CH-1:0] w_vint;
  logic [c_NUM_CH-1:0] w_under;
  llc_in_pkt_t         w_data [c_NUM_CH];
  llc_in_pkt_t         w_head [c_NUM_CH];
`ifdef LLC_INPUT_STATS_EN
  logic [15:0]         w_acc  [c_NUM_CH];
`endif

  assign w_valid[CH_RST_TB]     = rst_tb_valid;
  assign w_valid[CH_RSP_IN]     = rsp_in_valid;
  assign w_valid[CH_REQ_IN]     = req_in_valid;
  assign w_valid[CH_DMA_REQ_IN] = dma_req_in_valid;

  assign w_data[CH_RST_TB]      = rst_tb_data;
  assign w_data[CH_RSP_IN]      = rsp_in_data;
  assign w_data[CH_REQ_IN]      = req_in_data;
  assign w_data[CH_DMA_REQ_IN]  = dma_req_in_data;

  assign w_get[CH_RST_TB]       = get_rst_tb;
  assign w_get[CH_RSP_IN]       = get_rsp_in;
  assign w_get[CH_REQ_IN]       = get_req_in;
  assign w_get[CH_DMA_REQ_IN]   = get_dma_req_in;

  for (genvar g = 0; g < int'(c_NUM_CH); g++) begin : g_ch
    llc_input_fifo #(
      .DEPTH        (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (w_valid[g]),
      .push_ready_o (w_ready[g]),
      .push_data_i  (w_data[g]),
      .pop_i        (w_get[g]),
      .head_valid_o (w_vint[g]),
      .head_o       (w_head[g]),
      .underflow_o  (w_under[g])
`ifdef LLC_INPUT_STATS_EN
      ,
      .accept_cnt_o (w_acc[g])
`endif
    );
  end

  assign rst_tb_ready             = w_ready[CH_RST_TB];
  assign rsp_in_ready             = w_ready[CH_RSP_IN];
  assign req_in_ready             = w_ready[CH_REQ_IN];
  assign dma_req_in_ready         = w_ready[CH_DMA_REQ_IN];

  assign llc_rst_tb_valid_int     = w_vint[CH_RST_TB];
  assign llc_rsp_in_valid_int     = w_vint[CH_RSP_IN];
  assign llc_req_in_valid_int     = w_vint[CH_REQ_IN];
  assign llc_dma_req_in_valid_int = w_vint[CH_DMA_REQ_IN];

  assign rst_tb_head              = w_head[CH_RST_TB];
  assign rsp_in_head              = w_head[CH_RSP_IN];
  assign req_in_head              = w_head[CH_REQ_IN];
  assign dma_req_in_head          = w_head[CH_DMA_REQ_IN];

  // A single sticky error line: any channel popped while empty.
  assign underflow_err            = |w_under;

`ifdef LLC_INPUT_STATS_EN
  assign rst_tb_accept_cnt        = w_acc[CH_RST_TB];
  assign rsp_in_accept_cnt        = w_acc[CH_RSP_IN];
  assign req_in_accept_cnt        = w_acc[CH_REQ_IN];
  assign dma_req_in_accept_cnt    = w_acc[CH_DMA_REQ_IN];
`endif

endmodule

`default_nettype wire

// File: tb/tb_llc_input_stage.sv
// +----------------------------------------------------------------------+
// | tb_llc_input_stage : self-checking bench with a queue-based model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_llc_input_stage;
  import llc_input_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int NCH   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] valid;
  logic [NCH-1:0] get;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] vint;
  llc_in_pkt_t    data [NCH];
  llc_in_pkt_t    head [NCH];
  logic           underflow_err;
`ifdef LLC_INPUT_STATS_EN
  logic [15:0]    acc_cnt [NCH];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one unbounded queue per channel, capacity enforced by DEPTH.
  llc_in_pkt_t mq [NCH][$];
  bit          m_under;
  int unsigned m_acc [NCH];

  always #5 clk = ~clk;

  llc_input_stage #(.DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .rst_tb_valid             (valid[0]),
    .rst_tb_ready             (ready[0]),
    .rst_tb_data              (data[0]),
    .llc_rst_tb_valid_int     (vint[0]),
    .rst_tb_head              (head[0]),
    .get_rst_tb               (get[0]),
    .rsp_in_valid             (valid[1]),
    .rsp_in_ready             (ready[1]),
    .rsp_in_data              (data[1]),
    .llc_rsp_in_valid_int     (vint[1]),
    .rsp_in_head              (head[1]),
    .get_rsp_in               (get[1]),
    .req_in_valid             (valid[2]),
    .req_in_ready             (ready[2]),
    .req_in_data              (data[2]),
    .llc_req_in_valid_int     (vint[2]),
    .req_in_head              (head[2]),
    .get_req_in               (get[2]),
    .dma_req_in_valid         (valid[3]),
    .dma_req_in_ready         (ready[3]),
    .dma_req_in_data          (data[3]),
    .llc_dma_req_in_valid_int (vint[3]),
    .dma_req_in_head          (head[3]),
    .get_dma_req_in           (get[3]),
    .underflow_err            (underflow_err)
`ifdef LLC_INPUT_STATS_EN
    ,
    .rst_tb_accept_cnt        (acc_cnt[0]),
    .rsp_in_accept_cnt        (acc_cnt[1]),
    .req_in_accept_cnt        (acc_cnt[2]),
    .dma_req_in_accept_cnt    (acc_cnt[3])
`endif
  );

  function automatic llc_in_pkt_t mk(input int unsigned addr, input int unsigned msg);
    llc_in_pkt_t p;
    p.addr = line_addr_t'(addr);
    p.msg  = 4'(msg);
    return p;
  endfunction

  task automatic idle();
    valid = '0;
    get   = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_acc[c] = 0;
    end
    m_under = 1'b0;
  endtask

  // One clock: model consumes the same inputs the DUT sees at this edge.
  task automatic cycle();
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      bit do_push;
      bit do_pop;
      do_push = valid[c] && (mq[c].size() < DEPTH);
      do_pop  = get[c] && (mq[c].size() != 0);
      if (get[c] && (mq[c].size() == 0)) m_under = 1'b1;
      if (do_pop) void'(mq[c].pop_front());
      if (do_push) begin
        mq[c].push_back(data[c]);
        m_acc[c]++;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    for (int c = 0; c < NCH; c++) data[c] = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ready: got %b expected 0000", ready);
    end
    n_cmp++;
    if (vint !== 4'b0000) begin
      n_bad++; $display("FAIL reset_vint: got %b expected 0000", vint);
    end
    n_cmp++;
    if (underflow_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_underflow: got %b expected 0", underflow_err);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (ready !== 4'b1111) begin
      n_bad++; $display("FAIL post_reset_ready: got %b expected 1111", ready);
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (head[c] !== '0) begin
        n_bad++; $display("FAIL post_reset_head%0d: got %h expected 0", c, head[c]);
      end
    end
  endtask

  task automatic test_fill_no_get();
    idle();
    valid[2] = 1'b1; data[2] = mk(32'h0A0, 1);
    cycle();
    n_cmp++;
    if (ready[2] !== 1'b1) begin
      n_bad++; $display("FAIL fill_ready_after1: got %b expected 1", ready[2]);
    end
    data[2] = mk(32'h0B0, 2);
    cycle();
    idle();
    n_cmp++;
    if (ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL fill_ready_full: got %b expected 0", ready[2]);
    end
    n_cmp++;
    if (vint !== 4'b0100) begin
      n_bad++; $display("FAIL fill_vint: got %b expected 0100", vint);
    end
    n_cmp++;
    if (head[2].addr !== line_addr_t'(32'h0A0)) begin
      n_bad++; $display("FAIL fill_head: got %h expected 0a0", head[2].addr);
    end
    // Held full while valid stays high: nothing new enters.
    valid[2] = 1'b1; data[2] = mk(32'h0C0, 3);
    cycle();
    idle();
    n_cmp++;
    if (head[2].addr !== line_addr_t'(32'h0A0) || ready[2] !== 1'b0) begin
      n_bad++; $display("FAIL fill_hold: got head %h ready %b expected 0a0 0", head[2].addr, ready[2]);
    end
  endtask

  task automatic test_full_pop_push();
    idle();
    valid[1] = 1'b1; data[1] = mk(32'h100, 4);
    cycle();
    data[1] = mk(32'h101, 5);
    cycle();
    data[1] = mk(32'h102, 6);
    get[1]  = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if (ready[1] !== 1'b1 || vint[1] !== 1'b1) begin
      n_bad++; $display("FAIL fullpop_state: got ready %b vint %b expected 1 1", ready[1], vint[1]);
    end
    n_cmp++;
    if (head[1] !== mk(32'h101, 5)) begin
      n_bad++; $display("FAIL fullpop_head: got %h expected %h", head[1], mk(32'h101, 5));
    end
    get[1] = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if (vint[1] !== 1'b0) begin
      n_bad++; $display("FAIL fullpop_not_pushed: got vint %b expected 0", vint[1]);
    end
  endtask

  task automatic test_wrap_order();
    idle();
    valid[3] = 1'b1; data[3] = mk(32'h10, 0);
    cycle();
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if (vint[3] !== 1'b1 || head[3].addr !== line_addr_t'(32'h10 + i - 1)) begin
        n_bad++; $display("FAIL wrap_head%0d: got %b/%h expected 1/%h", i, vint[3], head[3].addr, 32'h10 + i - 1);
      end
      valid[3] = 1'b1; get[3] = 1'b1; data[3] = mk(32'h10 + i, i);
      cycle();
    end
    idle();
    n_cmp++;
    if (head[3].addr !== line_addr_t'(32'h15)) begin
      n_bad++; $display("FAIL wrap_last: got %h expected 15", head[3].addr);
    end
    get[3] = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if (vint[3] !== 1'b0 || underflow_err !== 1'b0) begin
      n_bad++; $display("FAIL wrap_drain: got vint %b uf %b expected 0 0", vint[3], underflow_err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        valid[c] = ($urandom_range(0, 99) < 55);
        get[c]   = ($urandom_range(0, 99) < 45);
        data[c]  = mk($urandom, $urandom_range(0, 15));
      end
      cycle();
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if (ready[c] !== (mq[c].size() != DEPTH) || vint[c] !== (mq[c].size() != 0)) begin
          n_bad++; $display("FAIL rand_flags ch%0d: got r%b v%b expected r%b v%b", c, ready[c], vint[c], mq[c].size() != DEPTH, mq[c].size() != 0);
        end
        if (mq[c].size() != 0) begin
          n_cmp++;
          if (head[c] !== mq[c][0]) begin
            n_bad++; $display("FAIL rand_head ch%0d: got %h expected %h", c, head[c], mq[c][0]);
          end
        end
      end
      n_cmp++;
      if (underflow_err !== m_under) begin
        n_bad++; $display("FAIL rand_underflow: got %b expected %b", underflow_err, m_under);
      end
    end
    idle();
  endtask

  task automatic test_underflow();
    apply_reset();
    n_cmp++;
    if (underflow_err !== 1'b0) begin
      n_bad++; $display("FAIL uf_clear: got %b expected 0", underflow_err);
    end
    get[0] = 1'b1;
    valid[1] = 1'b1; data[1] = mk(32'h77, 7);
    cycle();
    idle();
    n_cmp++;
    if (underflow_err !== 1'b1) begin
      n_bad++; $display("FAIL uf_set: got %b expected 1", underflow_err);
    end
    n_cmp++;
    if (vint !== 4'b0010 || head[1].addr !== line_addr_t'(32'h77) || ready !== 4'b1111) begin
      n_bad++; $display("FAIL uf_others: got vint %b head1 %h ready %b expected 0010 77 1111", vint, head[1].addr, ready);
    end
    repeat (3) cycle();
    n_cmp++;
    if (underflow_err !== 1'b1) begin
      n_bad++; $display("FAIL uf_sticky: got %b expected 1", underflow_err);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    valid = 4'b1111;
    for (int c = 0; c < NCH; c++) data[c] = mk(32'h200 + c, c + 1);
    cycle();
    idle();
    n_cmp++;
    if (vint !== 4'b1111) begin
      n_bad++; $display("FAIL midrst_loaded: got %b expected 1111", vint);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (vint !== 4'b0000 || ready !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_async: got vint %b ready %b expected 0000 0000", vint, ready);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (ready !== 4'b1111 || vint !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_release: got ready %b vint %b expected 1111 0000", ready, vint);
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (head[c] !== '0) begin
        n_bad++; $display("FAIL midrst_head%0d: got %h expected 0", c, head[c]);
      end
    end
  endtask

`ifdef LLC_INPUT_STATS_EN
  task automatic test_stats();
    apply_reset();
    valid[2] = 1'b1;
    for (int n = 0; n < 70000; n++) begin
      data[2] = mk(n, n);
      get[2]  = (n != 0);
      cycle();
      if (n == 4) begin
        n_cmp++;
        if (acc_cnt[2] !== 16'(m_acc[2])) begin
          n_bad++; $display("FAIL stats_early: got %0d expected %0d", acc_cnt[2], m_acc[2]);
        end
      end
    end
    idle();
    n_cmp++;
    if (acc_cnt[2] !== 16'hFFFF || m_acc[2] < 32'd65535) begin
      n_bad++; $display("FAIL stats_sat: got %h expected ffff (model %0d)", acc_cnt[2], m_acc[2]);
    end
    n_cmp++;
    if (acc_cnt[0] !== 16'd0 || acc_cnt[3] !== 16'd0) begin
      n_bad++; $display("FAIL stats_idle: got %0d/%0d expected 0/0", acc_cnt[0], acc_cnt[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_no_get();
    test_full_pop_push();
    test_wrap_order();
    test_random();
    test_underflow();
    test_reset_midop();
`ifdef LLC_INPUT_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
